// File: rtl/seq_multiplier_hs.sv
// Shift-add sequential multiplier, one multiplier bit per clock, with valid/ready
// handshakes on operand input and product output and per-operation signed mode.
module seq_multiplier_hs #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     factor1,
    input  logic [WIDTH-1:0]     factor2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; ready never depends combinationally on valid, and an offered product
    // holds stable until taken.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 neg;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 sign1;
    logic                 sign2;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;

    // Magnitudes are taken as unsigned, so the most negative operand maps cleanly.
    always_comb begin
        sign1    = signed_mode & factor1[WIDTH-1];
        sign2    = signed_mode & factor2[WIDTH-1];
        mag1     = sign1 ? (~factor1 + 1'b1) : factor1;
        mag2     = sign2 ? (~factor2 + 1'b1) : factor2;
        addend   = mplier[cnt] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        acc_next = acc + addend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= mag1;
                        mplier <= mag2;
                        neg    <= sign1 ^ sign2;
                        cnt    <= '0;
                        acc    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        product <= neg ? (~acc_next + 1'b1) : acc_next;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Bench for seq_multiplier_hs: WIDTH=8 and WIDTH=4 instances, queue scoreboards fed
// by the drivers and drained by independent output monitors.
module tb_seq_multiplier_hs;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [7:0]  factor1, factor2;
    logic [15:0] product;
    logic [1:0]  dbg_state;

    logic        in_valid4, in_ready4, signed_mode4, out_valid4, out_ready4, busy4;
    logic [3:0]  factor1_4, factor2_4;
    logic [7:0]  product4;
    logic [1:0]  dbg_state4;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          ready_rand = 0;
    logic        ov_prev = 0;
    logic        ov_prev4 = 0;

    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic [7:0]  exp4_q[$];
    int          acc4_q[$];

    seq_multiplier_hs #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .factor1(factor1), .factor2(factor2),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .busy(busy), .dbg_state(dbg_state)
    );

    seq_multiplier_hs #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .signed_mode(signed_mode4), .factor1(factor1_4), .factor2(factor2_4),
        .out_valid(out_valid4), .out_ready(out_ready4), .product(product4),
        .busy(busy4), .dbg_state(dbg_state4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check helpers ----------------
    task automatic chk(string nm, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic flag(string nm, string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", nm, what);
    endtask

    // Reference: plain integer multiply of the interpreted operand values.
    function automatic longint ref_mul(longint a, longint b, int w, bit sm);
        longint one = 1;
        if (sm) begin
            if (a[w-1]) a = a - (one << w);
            if (b[w-1]) b = b - (one << w);
        end
        return (a * b) & ((one << (2 * w)) - 1);
    endfunction

    // ---------------- drivers ----------------
    task automatic send(logic [7:0] a, logic [7:0] b, logic sm, logic [15:0] e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            flag("send8_timeout", "in_ready never rose within 200 cycles");
            return;
        end
        factor1 = a; factor2 = b; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
    endtask

    task automatic send4(logic [3:0] a, logic [3:0] b, logic [7:0] e);
        int n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready4) begin
            flag("send4_timeout", "in_ready never rose within 200 cycles");
            return;
        end
        factor1_4 = a; factor2_4 = b; in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        exp4_q.push_back(e);
        acc4_q.push_back(cyc);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || exp4_q.size() != 0)
            flag("drain_timeout", "expected results never presented");
    endtask

    always @(posedge clk) begin
        if (ready_rand) begin
            #2;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !ov_prev) begin
                if (acc_q.size() != 0) chk("latency8", longint'(cyc - acc_q.pop_front()), 8);
                else flag("out_valid8", "rose with no operation in flight");
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) chk("product8", longint'(product), longint'(exp_q.pop_front()));
                else flag("product8", "result taken with empty expected queue");
            end
        end
        ov_prev = out_valid;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid4 && !ov_prev4) begin
                if (acc4_q.size() != 0) chk("latency4", longint'(cyc - acc4_q.pop_front()), 4);
                else flag("out_valid4", "rose with no operation in flight");
            end
            if (out_valid4 && out_ready4) begin
                if (exp4_q.size() != 0) chk("product4", longint'(product4), longint'(exp4_q.pop_front()));
                else flag("product4", "result taken with empty expected queue");
            end
        end
        ov_prev4 = out_valid4;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] held;
        logic [7:0]  ra, rb;
        logic        rs;
        int          n;

        reset = 1'b1;
        in_valid = 0; signed_mode = 0; factor1 = 0; factor2 = 0; out_ready = 1'b1;
        in_valid4 = 0; signed_mode4 = 0; factor1_4 = 0; factor2_4 = 0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        chk("rst_product4", product4, 0);

        // WIDTH=4 unsigned
        send4(4'd2, 4'd1, 8'h02);
        send4(4'd2, 4'd2, 8'h04);
        send4(4'd15, 4'd15, 8'hE1);
        drain();

        // WIDTH=8 signed corners, unsigned max, zero operands
        send(8'h80, 8'h80, 1'b1, 16'h4000);
        send(8'd127, 8'h80, 1'b1, 16'hC080);
        send(8'hFF, 8'h01, 1'b1, 16'hFFFF);
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        send(8'd0, 8'd200, 1'b0, 16'h0000);
        send(8'd200, 8'd0, 1'b0, 16'h0000);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(8'd13, 8'd11, 1'b0, 16'd143);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) flag("bp_wait", "out_valid never rose");
        held = product;
        chk("bp_held_value", held, 16'd143);
        repeat (20) begin
            @(negedge clk);
            chk("bp_product_stable", product, held);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_out_valid_fall", out_valid, 0);
        chk("bp_in_ready_rise", in_ready, 1);
        chk("bp_product_kept", product, held);
        out_ready = 1'b1;

        // Input isolation during CALC
        send(8'd3, 8'd5, 1'b0, 16'h000F);
        repeat (7) begin
            @(negedge clk);
            factor1 = 8'($urandom); factor2 = 8'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Reset mid-calculation
        send(8'd100, 8'd100, 1'b0, 16'd10000);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_product", product, 0);
        repeat (12) @(negedge clk);
        send(8'd7, 8'd9, 1'b0, 16'h003F);
        drain();

        // Randomized traffic with random backpressure
        ready_rand = 1;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, 16'(ref_mul(longint'(ra), longint'(rb), 8, rs)));
        end
        drain();
        ready_rand = 0;
        @(posedge clk);
        #3 out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_multiplier_hs.md
# seq_multiplier_hs

Parametrised shift-add sequential multiplier with a valid/ready handshake on both sides and a per-operation signed/unsigned mode. It accepts one operand pair, computes the full 2*WIDTH-bit product at one multiplier bit per clock, and holds the result until the consumer takes it. It is the next-generation drop-in for datapaths that previously drove the plain load/enable 4-bit multiplier, and adds width scaling, two's-complement support and backpressure.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits
- clk  input  1  sole clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; sampled on rising clk
- in_valid  input  1  operand pair and mode are valid this cycle
- in_ready  output  1  block can accept an operand pair; high only in IDLE
- signed_mode  input  1  1 = treat factor1/factor2 as two's complement, 0 = unsigned; sampled at accept
- factor1  input  WIDTH  multiplicand
- factor2  input  WIDTH  multiplier
- out_valid  output  1  product holds a completed result
- out_ready  input  1  consumer takes the product this cycle
- product  output  2*WIDTH  result; held stable while out_valid is high
- busy  output  1  high in CALC or DONE

## Operation
- States: IDLE, CALC, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture the operands and signed_mode, then go to CALC with bit counter=0.
- Capture rule: in signed mode, store operand magnitudes as unsigned WIDTH-bit values. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits without overflow. Also store result sign = sign1 XOR sign2. In unsigned mode, store the operands as-is with result sign 0.
- CALC: each cycle, if the current multiplier bit (LSB first) is 1, add the multiplicand shifted by counter into the 2*WIDTH-bit accumulator. Then increment the counter.
- On the CALC cycle with counter=WIDTH-1:
  - Load product with the final accumulator value, two's-complement negated in 2*WIDTH bits if result sign=1.
  - Go to DONE.
- Inputs factor1/factor2/signed_mode/in_valid are ignored outside IDLE; changing them in CALC has no effect.
- DONE: out_valid=1, product stable. On out_ready=1, go to IDLE. No new accept occurs in the same cycle because in_ready=0 in DONE.
- product keeps its last value after the handshake until the next DONE load. It is never updated during CALC.
- No overflow is possible. The full-range result always fits in 2*WIDTH bits, for example (-2^(W-1))^2 = 2^(2W-2).
- Zero operands take the full WIDTH cycles; there is no early termination.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, product=0, accumulator/counter=0.
- Reset asserted in any state takes effect at the next rising edge: state=IDLE, outputs at reset values, any in-flight operation discarded and never presented.
- Reset takes priority over a simultaneous accept or out handshake.
- Latency:
  - Accept at edge E.
  - CALC occupies edges E+1..E+WIDTH.
  - out_valid=1 and product valid from just after edge E+WIDTH.
- Handshake out at the first edge where out_valid&&out_ready. in_ready rises just after that edge.
- Maximum throughput is one operation per WIDTH+2 cycles, reached when out_ready is held high.
- out_valid stays high indefinitely under backpressure. product and out_valid must not glitch or change while waiting.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from inputs.

## Test plan
- WIDTH=4, unsigned, out_ready=1: 2×1, then 2×2, then 15×15. Products must be 0x02, 0x04 and 0xE1 (225). out_valid rises 4 cycles after each accept edge.
- WIDTH=8, signed: -128×-128 must give 0x4000. 127×-128 must give 0xC080 (-16256). -1×1 must give 0xFFFF. Run 0xFF×0xFF in unsigned mode and require 0xFE01.
- WIDTH=8, zero operands: 0×200 and 200×0 (unsigned) must give 0x0000, with the same 8-cycle latency.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid rises. product stays constant and in_ready stays 0 throughout. Then raise out_ready for 1 cycle; out_valid falls and in_ready rises the next cycle.
- Input isolation: accept 3×5 (WIDTH=8), then toggle factor1/factor2/signed_mode/in_valid every cycle during CALC. Result must still be 0x000F.
- Reset mid-CALC: accept 100×100, assert reset for 1 cycle at counter=4. Next cycle requires IDLE, in_ready=1, out_valid=0 and product=0, and no stale result is ever presented. A following 7×9 must give 0x003F.
